hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall/flush controller: memory wait, load-use, branch redirect arbitration.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters (ports always present).
module hazard_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_busy,
    input  logic                      mem_busy,
    input  logic                      ex_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic                      ex_mispredict,
    input  logic [ADDR_WIDTH-1:0]     ex_target,
    output logic [1:0]                pc_sf,
    output logic [1:0]                ifid_sf,
    output logic [1:0]                idex_sf,
    output logic [1:0]                exmem_sf,
    output logic [1:0]                memwb_sf,
    output logic                      redirect_valid,
    output logic [ADDR_WIDTH-1:0]     redirect_addr,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_flush_cnt
);

    localparam logic [1:0] SF_NORMAL = 2'b00;
    localparam logic [1:0] SF_STALL  = 2'b01;
    localparam logic [1:0] SF_FLUSH  = 2'b10;

    typedef enum logic {RUN, REDIR_WAIT} state_t;

    state_t                state, state_nxt;
    logic                  pend_valid, pend_valid_nxt;
    logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_nxt;
    logic                  load_use;
    logic [ADDR_WIDTH-1:0] redir_target;

    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign redir_target = pend_valid ? pend_addr : ex_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            state      <= state_nxt;
            pend_valid <= pend_valid_nxt;
            pend_addr  <= pend_addr_nxt;
        end
    end

    always_comb begin
        pc_sf          = SF_NORMAL;
        ifid_sf        = SF_NORMAL;
        idex_sf        = SF_NORMAL;
        exmem_sf       = SF_NORMAL;
        memwb_sf       = SF_NORMAL;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        state_nxt      = state;
        pend_valid_nxt = pend_valid;
        pend_addr_nxt  = pend_addr;

        if (reset) begin
            pc_sf    = SF_FLUSH;
            ifid_sf  = SF_FLUSH;
            idex_sf  = SF_FLUSH;
            exmem_sf = SF_FLUSH;
            memwb_sf = SF_FLUSH;
        end else if (mem_busy) begin
            pc_sf    = SF_STALL;
            ifid_sf  = SF_STALL;
            idex_sf  = SF_STALL;
            exmem_sf = SF_STALL;
            memwb_sf = SF_FLUSH;
            // Capture only the first mispredict; a held EX instruction re-asserts it every cycle.
            if (ex_mispredict && !pend_valid) begin
                pend_valid_nxt = 1'b1;
                pend_addr_nxt  = ex_target;
            end
        end else if ((state == RUN) && (pend_valid || ex_mispredict)) begin
            ifid_sf = SF_FLUSH;
            idex_sf = SF_FLUSH;
            if (!if_busy) begin
                redirect_valid = 1'b1;
                redirect_addr  = redir_target;
                pend_valid_nxt = 1'b0;
            end else begin
                pc_sf          = SF_STALL;
                pend_valid_nxt = 1'b1;
                pend_addr_nxt  = redir_target;
                state_nxt      = REDIR_WAIT;
            end
        end else if (state == REDIR_WAIT) begin
            ifid_sf = SF_FLUSH;
            idex_sf = SF_FLUSH;
            if (if_busy) begin
                pc_sf = SF_STALL;
            end else begin
                redirect_valid = 1'b1;
                redirect_addr  = pend_addr;
                pend_valid_nxt = 1'b0;
                state_nxt      = RUN;
            end
        end else if (load_use) begin
            pc_sf   = SF_STALL;
            ifid_sf = SF_STALL;
            idex_sf = SF_FLUSH;
        end else if (if_busy) begin
            pc_sf   = SF_STALL;
            ifid_sf = SF_FLUSH;
        end
    end

`ifdef HAZARD_PERF_EN
    // Flops are held in reset, so reset-cycle flushes are never counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if ((pc_sf == SF_STALL) && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if ((idex_sf == SF_FLUSH) && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
